msx_mouse_port: RTL

- Parametrised MSX general-purpose-port adapter. Converts host mouse deltas and buttons into the MSX strobe-clocked 4-nibble mouse protocol, or passes joystick lines through.
- Successor to the inline single-port mouse encoder: adds delta accumulation with saturation and residual carry, a configurable scale and inversion, a mode select and a parametrised timeout.
- One instance per MSX port. It sits between the user_io mouse/joystick outputs and the emsx_top pJoyA/pJoyB inputs.

---
 rtl/msx_mouse_port.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/msx_mouse_port.sv
// MSX general-purpose port adapter: host mouse deltas/buttons -> strobe-clocked
// 4-nibble MSX mouse protocol, or joystick pass-through, one instance per port.
module msx_mouse_port #(
  parameter int ACC_W       = 12,
  parameter int SCALE_SHIFT = 1,
  parameter int TIMEOUT     = 100000,
  parameter bit INVERT_X    = 1'b1,
  parameter bit INVERT_Y    = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic [1:0] mouse_btn,
  input  logic [5:0] joy_in,
  input  logic       msx_str,
  output logic [5:0] port_out,
  output logic       mouse_active,
  output logic [1:0] nibble_idx
);

  // Extended width for acc + delta - consumed so saturation sees the true sum.
  localparam int EW = ACC_W + SCALE_SHIFT + 10;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] PH_X_HI = 2'd0;
  localparam logic [1:0] PH_X_LO = 2'd1;
  localparam logic [1:0] PH_Y_HI = 2'd2;
  localparam logic [1:0] PH_Y_LO = 2'd3;

  localparam logic signed [EW-1:0]    ACC_MAX  = EW'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [EW-1:0]    ACC_MIN  = EW'(-(2 ** (ACC_W - 1)));
  localparam logic signed [ACC_W-1:0] SNAP_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SNAP_MIN = ACC_W'(-128);
  localparam logic [CW-1:0]           TMO_LOAD = CW'(TIMEOUT);
  localparam logic [CW-1:0]           TMO_ONE  = CW'(1);

  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [EW-1:0] v);
    if (v > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
    else                  sat_acc = v[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > SNAP_MAX)      sat8 = 8'h7F;
    else if (v < SNAP_MIN) sat8 = 8'h80;
    else                   sat8 = v[7:0];
  endfunction

  logic                    r_s1, r_s2, r_s3;
  logic                    r_active;
  logic [1:0]              r_idx;
  logic [CW-1:0]           r_tmo;
  logic signed [ACC_W-1:0] r_acc_x, r_acc_y;
  logic [3:0]              r_snap_x_lo;
  logic [7:0]              r_snap_y;
  logic [3:0]              r_nibble;
  logic [5:0]              r_port;

  logic                    w_edge, w_take;
  logic signed [ACC_W-1:0] w_dx_ext, w_dy_ext, w_dx, w_dy, w_sh_x, w_sh_y;
  logic [7:0]              w_snap_x, w_snap_y;
  logic signed [EW-1:0]    w_add_x, w_add_y, w_cons_x, w_cons_y, w_sum_x, w_sum_y;

  assign w_edge = r_s2 ^ r_s3;
  assign w_take = r_active & w_edge & (r_idx == PH_X_HI);

  // mouse_strobe is a one-cycle valid with no ready: every delta is absorbed.
  assign w_dx_ext = {{(ACC_W-9){mouse_dx[8]}}, mouse_dx};
  assign w_dy_ext = {{(ACC_W-9){mouse_dy[8]}}, mouse_dy};
  assign w_dx     = INVERT_X ? -w_dx_ext : w_dx_ext;
  assign w_dy     = INVERT_Y ? -w_dy_ext : w_dy_ext;

  assign w_sh_x   = r_acc_x >>> SCALE_SHIFT;
  assign w_sh_y   = r_acc_y >>> SCALE_SHIFT;
  assign w_snap_x = sat8(w_sh_x);
  assign w_snap_y = sat8(w_sh_y);

  assign w_add_x  = mouse_strobe ? {{(EW-ACC_W){w_dx[ACC_W-1]}}, w_dx} : '0;
  assign w_add_y  = mouse_strobe ? {{(EW-ACC_W){w_dy[ACC_W-1]}}, w_dy} : '0;
  // Only the reported amount leaves the accumulator; the residual carries over.
  assign w_cons_x = w_take ? ({{(EW-8){w_snap_x[7]}}, w_snap_x} <<< SCALE_SHIFT) : '0;
  assign w_cons_y = w_take ? ({{(EW-8){w_snap_y[7]}}, w_snap_y} <<< SCALE_SHIFT) : '0;
  assign w_sum_x  = {{(EW-ACC_W){r_acc_x[ACC_W-1]}}, r_acc_x} + w_add_x - w_cons_x;
  assign w_sum_y  = {{(EW-ACC_W){r_acc_y[ACC_W-1]}}, r_acc_y} + w_add_y - w_cons_y;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_active    <= 1'b0;
      r_idx       <= PH_X_HI;
      r_tmo       <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_snap_x_lo <= '0;
      r_snap_y    <= '0;
      r_nibble    <= '0;
      r_port      <= 6'h3F;
    end else begin
      r_s1 <= msx_str;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      case (mode)
        2'd1:    r_active <= 1'b0;
        2'd2:    r_active <= 1'b1;
        default: begin
          if (mouse_strobe)        r_active <= 1'b1;
          else if (joy_in != 6'h3F) r_active <= 1'b0;
        end
      endcase

      r_acc_x <= sat_acc(w_sum_x);
      r_acc_y <= sat_acc(w_sum_y);

      if (!r_active) begin
        r_idx <= PH_X_HI;
        r_tmo <= '0;
      end else if (w_edge) begin
        r_tmo <= TMO_LOAD;
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          PH_X_HI: begin
            r_snap_x_lo <= w_snap_x[3:0];
            r_snap_y    <= w_snap_y;
            r_nibble    <= w_snap_x[7:4];
          end
          PH_X_LO: r_nibble <= r_snap_x_lo;
          PH_Y_HI: r_nibble <= r_snap_y[7:4];
          PH_Y_LO: r_nibble <= r_snap_y[3:0];
        endcase
      end else if (r_tmo != '0) begin
        r_tmo <= r_tmo - TMO_ONE;
        if (r_tmo == TMO_ONE) r_idx <= PH_X_HI;
      end

      r_port <= r_active ? {~mouse_btn, r_nibble} : joy_in;
    end
  end

  assign port_out     = r_port;
  assign mouse_active = r_active;
  assign nibble_idx   = r_idx;

endmodule
